hex_display_scan_ctrl: RTL and testbench
========================================

// Module: hex_display_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one decoder.
//  Holds a NUM_DIGITS x 4-bit shadow value and steps through the digits one at a time.
//  For each digit it drives the nibble through an internal dcba27segments instance and pulses one anode.
//  Sits between a value producer (counter/register file) and the board's display pins.
// PARAMETERS
//  NUM_DIGITS   4   number of multiplexed digits (>=2)
//  REFRESH_DIV  1000  clk cycles each digit is lit (SHOW phase, >=1)
//  DEAD_CYCLES  2   clk cycles all anodes off between digits (BLANK phase, >=1), anti-ghosting
// PORTS
//  clk         in   1             system clock, rising edge
//  rst_n       in   1             asynchronous reset, active low
//  en          in   1             scan enable; low = display dark, scan frozen
//  load        in   1             capture digits_in into shadow this cycle
//  digits_in   in   4*NUM_DIGITS  nibble i at [4i+3:4i], digit 0 = rightmost
//  blank_mask  in   NUM_DIGITS    1 = digit i never lit (its slot still timed)
//  digit_sel   out  NUM_DIGITS    anode drive, active low, one-hot-zero during SHOW
//  seg_out     out  7             segments a..g = [6:0], active low, registered
//  frame_done  out  1             1-cycle pulse on leaving SHOW of digit NUM_DIGITS-1
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//  - shadow=0, idx=0, cnt=0, state=BLANK.
//  - digit_sel=all 1, seg_out=7'b1111111, frame_done=0.
//  FSM, 2 states:
//  - BLANK: digit_sel=all 1, seg_out=all 1. After DEAD_CYCLES cycles -> SHOW.
//    On that edge, seg_out <= decode(shadow nibble idx) and digit_sel[idx] <= 0 (both registered).
//  - SHOW: outputs held for REFRESH_DIV cycles -> BLANK.
//    On that edge, idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
//    frame_done=1 for that one cycle when idx was NUM_DIGITS-1.
//  cnt width: $clog2(max(REFRESH_DIV,DEAD_CYCLES)+1); cleared on every state change.
//  Digit period: REFRESH_DIV+DEAD_CYCLES cycles. Frame period: NUM_DIGITS x digit period.
//  First lit digit after reset: digit 0, digit_sel low in cycle DEAD_CYCLES+1 after release with en=1.
//  load: shadow <= digits_in on the same edge.
//  - The nibble is sampled only at BLANK->SHOW, so a lit digit never changes mid-SHOW (no tearing).
//  - load during reset is ignored.
//  blank_mask[idx]=1 at BLANK->SHOW: digit_sel stays all 1, seg_out stays all 1; timing is unchanged.
//  en=0: next edge forces state=BLANK, cnt=0, digit_sel/seg_out all 1, frame_done=0; idx held.
//  - en=1 again: full DEAD_CYCLES BLANK, then SHOW at the held idx.
//  - load is still honoured while en=0.
//  Mid-operation reset: immediately returns to reset values; the shadow value is lost.
//  Never more than one digit_sel bit low; never low in BLANK.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digit i (i>=1) is blanked when shadow nibbles i..NUM_DIGITS-1 are all 0.
//  - Evaluated at BLANK->SHOW and ORed with blank_mask.
//  - Digit 0 is always shown unless masked.
//  Undefined: zero nibbles display as "0" like any other value; no extra logic is synthesised.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=2)
//  1. Reset asserted mid-SHOW -> same cycle digit_sel=4'b1111, seg_out=7'b1111111, frame_done=0.
//  2. load 16'h12AF, en=1 -> 2 cycles dark, then:
//     - 1110/0111000 (F) for 4 cycles, then 2 cycles dark;
//     - 1101/0001000 (A), 1011/0010010 (2), 0111/1001111 (1);
//     - frame_done pulses once per 24 cycles.
//  3. load 16'h0003 in 2nd cycle of digit-0 SHOW (digit 0 currently 4'h5) -> digit 0 stays 0100100 until BLANK.
//     Next frame shows 0000110.
//  4. blank_mask=4'b0100 -> digit-2 slot: digit_sel=1111 for 4 cycles; all other slots and frame period unchanged.
//  5. en=0 during SHOW of digit 1 for 3 cycles -> digit_sel=1111 next edge; after en=1: 2 dark cycles, then digit_sel=1101.
//  6. LEADING_ZERO_BLANK_EN, value 16'h0050 -> digits 3,2 dark; digit 1 shows 0100100; digit 0 shows 0000001.
//     Without the macro: digits 3,2 show 0000001.

Source files
------------

// File: rtl/hex_display_scan_ctrl.sv
// hex_display_scan_ctrl: time-multiplexed 7-segment scan controller with a BLANK/SHOW anti-ghosting FSM.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits above digit 0.
module dcba27segments (
    input  logic [3:0] dcba,
    output logic [6:0] seg
);
    // segments a..g on [6:0], active low
    always_comb begin
        seg = 7'b1111111;
        case (dcba)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end
endmodule

module hex_display_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg_out,
    output logic                    frame_done
);
    localparam int MAX_CNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(NUM_DIGITS);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [IW-1:0]           idx, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   lz_blank, digit_sel_d;
    logic [6:0]              seg_dec, seg_d;
    logic                    frame_done_d, tick, to_show, hold_show, lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (load)
            shadow <= digits_in;
    end

    dcba27segments u_dec (
        .dcba (shadow[4*idx +: 4]),
        .seg  (seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // zero_above[i]: nibbles i..NUM_DIGITS-1 are all zero
    logic [NUM_DIGITS:1] zero_above;
    assign zero_above[NUM_DIGITS] = 1'b1;
    assign lz_blank[0]            = 1'b0;
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
        assign zero_above[i] = zero_above[i+1] && (shadow[4*i +: 4] == 4'h0);
        assign lz_blank[i]   = zero_above[i];
    end
`else
    assign lz_blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            digit_sel  <= '1;
            seg_out    <= 7'b1111111;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            digit_sel  <= digit_sel_d;
            seg_out    <= seg_d;
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        tick    = (state == BLANK) ? (cnt == CW'(DEAD_CYCLES - 1)) : (cnt == CW'(REFRESH_DIV - 1));
        state_d = !en ? BLANK : tick ? ((state == BLANK) ? SHOW : BLANK) : state;
        cnt_d   = (!en || tick) ? '0 : cnt + 1'b1;
        idx_d   = (en && state == SHOW && tick) ? ((idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1) : idx;
    end

    // the nibble is sampled only on BLANK->SHOW, so a lit digit never tears
    always_comb begin
        to_show      = en && state == BLANK && tick;
        hold_show    = en && state == SHOW && !tick;
        lit          = !(blank_mask[idx] || lz_blank[idx]);
        digit_sel_d  = (to_show && lit) ? ~(NUM_DIGITS'(1) << idx) : hold_show ? digit_sel : '1;
        seg_d        = (to_show && lit) ? seg_dec : hold_show ? seg_out : 7'b1111111;
        frame_done_d = en && state == SHOW && tick && (idx == IW'(NUM_DIGITS - 1));
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~digit_sel));
    assert property (@(posedge clk) disable iff (!rst_n) (state == BLANK) |-> (&digit_sel));
endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// tb_hex_display_scan_ctrl: directed bench for hex_display_scan_ctrl (4 digits, REFRESH_DIV=4, DEAD_CYCLES=2).
module tb_hex_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  digit_sel;
    logic [6:0]  seg_out;
    logic        frame_done;
    int          compared = 0;
    int          mismatched = 0;

    hex_display_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .DEAD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .blank_mask (blank_mask),
        .digit_sel  (digit_sel),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // after return we sit at sample 1 (first negedge after release); digit 0 lights at sample 2
    task automatic restart(input logic [15:0] v, input logic [3:0] m);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        en         = 1'b1;
        load       = 1'b1;
        digits_in  = v;
        blank_mask = m;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        en        = 1'b1;
        load      = 1'b1;
        digits_in = 16'hFFFF;
        repeat (3) step();
        compared++;
        if (digit_sel !== 4'b1111) begin mismatched++; $display("FAIL reset digit_sel got %b want 1111", digit_sel); end
        compared++;
        if (seg_out !== 7'b1111111) begin mismatched++; $display("FAIL reset seg_out got %b want 1111111", seg_out); end
        compared++;
        if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset frame_done got %b want 0", frame_done); end
        load  = 1'b0;
        rst_n = 1'b1;
        step();
        compared++;
        if (digit_sel !== 4'b1111) begin mismatched++; $display("FAIL reset_first_dark digit_sel got %b want 1111", digit_sel); end
        step();
        compared++;
        if (digit_sel !== 4'b1110) begin mismatched++; $display("FAIL reset_first_lit digit_sel got %b want 1110", digit_sel); end
        compared++;
        if (seg_out !== 7'b0000001) begin mismatched++; $display("FAIL reset_load_ignored seg_out got %b want 0000001", seg_out); end
    endtask

    task automatic test_scan_frame();
        logic [6:0] fig [4];
        logic [3:0] es;
        logic [6:0] eg;
        logic       ef;
        int p, d;
        fig = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        restart(16'h12AF, 4'b0000);
        for (int s = 1; s <= 49; s++) begin
            if (s > 1) step();
            p  = (s - 2) % 6;
            d  = ((s - 2) / 6) % 4;
            es = (s >= 2 && p < 4) ? ~(4'b0001 << d) : 4'b1111;
            eg = (s >= 2 && p < 4) ? fig[d] : 7'b1111111;
            ef = (s % 24) == 0;
            compared++;
            if (digit_sel !== es) begin mismatched++; $display("FAIL scan s=%0d digit_sel got %b want %b", s, digit_sel, es); end
            compared++;
            if (seg_out !== eg) begin mismatched++; $display("FAIL scan s=%0d seg_out got %b want %b", s, seg_out, eg); end
            compared++;
            if (frame_done !== ef) begin mismatched++; $display("FAIL scan s=%0d frame_done got %b want %b", s, frame_done, ef); end
        end
    endtask

    task automatic test_async_reset();
        restart(16'h8888, 4'b0000);
        step();
        step();
        compared++;
        if (seg_out !== 7'b0000000) begin mismatched++; $display("FAIL areset_pre seg_out got %b want 0000000", seg_out); end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (digit_sel !== 4'b1111) begin mismatched++; $display("FAIL areset digit_sel got %b want 1111", digit_sel); end
        compared++;
        if (seg_out !== 7'b1111111) begin mismatched++; $display("FAIL areset seg_out got %b want 1111111", seg_out); end
        compared++;
        if (frame_done !== 1'b0) begin mismatched++; $display("FAIL areset frame_done got %b want 0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        compared++;
        if (digit_sel !== 4'b1110) begin mismatched++; $display("FAIL areset_relit digit_sel got %b want 1110", digit_sel); end
        compared++;
        if (seg_out !== 7'b0000001) begin mismatched++; $display("FAIL areset_shadow_lost seg_out got %b want 0000001", seg_out); end
    endtask

    task automatic test_load_no_tear();
        logic [6:0] eg;
        restart(16'h0005, 4'b0000);
        for (int s = 2; s <= 29; s++) begin
            step();
            if (s == 4) load = 1'b0;
            if ((s >= 2 && s <= 6) || s >= 26) begin
                eg = (s == 6) ? 7'b1111111 : (s >= 26) ? 7'b0000110 : 7'b0100100;
                compared++;
                if (seg_out !== eg) begin mismatched++; $display("FAIL no_tear s=%0d seg_out got %b want %b", s, seg_out, eg); end
                compared++;
                if (digit_sel !== ((s == 6) ? 4'b1111 : 4'b1110)) begin
                    mismatched++;
                    $display("FAIL no_tear s=%0d digit_sel got %b want %b", s, digit_sel, (s == 6) ? 4'b1111 : 4'b1110);
                end
            end
            if (s == 3) begin
                digits_in = 16'h0003;
                load      = 1'b1;
            end
        end
    endtask

    task automatic test_blank_mask();
        logic [6:0] fig [4];
        logic [3:0] es;
        logic [6:0] eg;
        logic       on;
        int p, d;
        fig = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        restart(16'h12AF, 4'b0100);
        for (int s = 1; s <= 48; s++) begin
            if (s > 1) step();
            p  = (s - 2) % 6;
            d  = ((s - 2) / 6) % 4;
            on = s >= 2 && p < 4 && d != 2;
            es = on ? ~(4'b0001 << d) : 4'b1111;
            eg = on ? fig[d] : 7'b1111111;
            compared++;
            if (digit_sel !== es) begin mismatched++; $display("FAIL mask s=%0d digit_sel got %b want %b", s, digit_sel, es); end
            compared++;
            if (seg_out !== eg) begin mismatched++; $display("FAIL mask s=%0d seg_out got %b want %b", s, seg_out, eg); end
            compared++;
            if (frame_done !== ((s % 24) == 0)) begin mismatched++; $display("FAIL mask s=%0d frame_done got %b want %b", s, frame_done, (s % 24) == 0); end
        end
        blank_mask = 4'b0000;
    endtask

    // en drops mid digit-1 SHOW; a load while dark must still land
    task automatic test_enable();
        logic [3:0] es;
        logic [6:0] eg;
        restart(16'h12AF, 4'b0000);
        for (int s = 2; s <= 18; s++) begin
            step();
            if (s >= 10) begin
                es = (s >= 14 && s <= 17) ? 4'b1101 : 4'b1111;
                eg = (s >= 14 && s <= 17) ? 7'b0000110 : 7'b1111111;
                compared++;
                if (digit_sel !== es) begin mismatched++; $display("FAIL enable s=%0d digit_sel got %b want %b", s, digit_sel, es); end
                compared++;
                if (seg_out !== eg) begin mismatched++; $display("FAIL enable s=%0d seg_out got %b want %b", s, seg_out, eg); end
            end
            compared++;
            if (frame_done !== 1'b0) begin mismatched++; $display("FAIL enable s=%0d frame_done got %b want 0", s, frame_done); end
            if (s == 9) en = 1'b0;
            if (s == 10) begin
                digits_in = 16'h3333;
                load      = 1'b1;
            end
            if (s == 11) load = 1'b0;
            if (s == 12) en = 1'b1;
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] es [4];
        logic [6:0] eg [4];
`ifdef LEADING_ZERO_BLANK_EN
        es = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        eg = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
`else
        es = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        eg = '{7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001};
`endif
        restart(16'h0050, 4'b0000);
        for (int s = 2; s <= 21; s++) begin
            step();
            if ((s - 2) % 6 == 1) begin
                compared++;
                if (digit_sel !== es[(s - 2) / 6]) begin mismatched++; $display("FAIL lz s=%0d digit_sel got %b want %b", s, digit_sel, es[(s - 2) / 6]); end
                compared++;
                if (seg_out !== eg[(s - 2) / 6]) begin mismatched++; $display("FAIL lz s=%0d seg_out got %b want %b", s, seg_out, eg[(s - 2) / 6]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_frame();
        test_async_reset();
        test_load_no_tear();
        test_blank_mask();
        test_enable();
        test_leading_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
